// File: rtl/mesi_isc_breq_pkg.sv
// Shared encodings, FSM states and width defaults for the broadcast-request
// arbiter and its consumer mesi_isc_broad.
package mesi_isc_breq_pkg;

    localparam int ADDR_WIDTH_DEF       = 32;
    localparam int BROAD_TYPE_WIDTH_DEF = 2;
    localparam int BROAD_ID_WIDTH_DEF   = 5;
    localparam int NUM_CPU_FIXED        = 4;
    localparam int STAT_WIDTH           = 16;

    localparam logic [1:0] BROAD_TYPE_NOP = 2'd0;
    localparam logic [1:0] BROAD_TYPE_WR  = 2'd1;
    localparam logic [1:0] BROAD_TYPE_RD  = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } breq_state_t;

endpackage

// File: rtl/mesi_isc_rr_arb4.sv
// Combinational 4-way round-robin picker: first set request searching upward
// from ptr+1 (mod 4); zero latency, no backpressure of its own.
module mesi_isc_rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx
);

    logic [1:0] cand;

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 4; i >= 1; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                gnt     = 4'b0001 << cand;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/mesi_isc_breq_arb.sv
// Round-robin broadcast-request arbiter feeding the broadcast FIFO; write/ack one cycle
// after the grant edge, one grant per 2 cycles, stalls while full. Stats: MESI_ISC_BREQ_STATS_EN.
module mesi_isc_breq_arb
    import mesi_isc_breq_pkg::*;
#(
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int BROAD_TYPE_WIDTH = BROAD_TYPE_WIDTH_DEF,
    parameter int BROAD_ID_WIDTH   = BROAD_ID_WIDTH_DEF,
    parameter int NUM_CPU          = NUM_CPU_FIXED
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CPU-1:0]                  breq_valid_array_i,
    input  logic [NUM_CPU*ADDR_WIDTH-1:0]       breq_addr_array_i,
    input  logic [NUM_CPU*BROAD_TYPE_WIDTH-1:0] breq_type_array_i,
    output logic [NUM_CPU-1:0]                  breq_ack_array_o,
    input  logic                                fifo_status_full_i,
    output logic                                broad_fifo_wr_o,
    output logic [ADDR_WIDTH-1:0]               broad_addr_o,
    output logic [BROAD_TYPE_WIDTH-1:0]         broad_type_o,
    output logic [1:0]                          broad_cpu_id_o,
`ifdef MESI_ISC_BREQ_STATS_EN
    output logic [NUM_CPU*STAT_WIDTH-1:0]       grant_cnt_array_o,
    output logic [STAT_WIDTH-1:0]               stall_cnt_o,
`endif
    output logic [BROAD_ID_WIDTH-1:0]           broad_id_o
);

    breq_state_t                 state;
    logic [1:0]                  ptr;
    logic [BROAD_ID_WIDTH-1:0]   id_cnt;
    logic [3:0]                  gnt;
    logic [1:0]                  gnt_idx;
    logic [ADDR_WIDTH-1:0]       sel_addr;
    logic [BROAD_TYPE_WIDTH-1:0] sel_type;
    logic                        sel_real;
    logic                        grant;

    mesi_isc_rr_arb4 u_rr_arb4 (
        .req     (breq_valid_array_i),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_addr = '0;
        sel_type = '0;
        for (int i = 0; i < NUM_CPU; i++) begin
            if (gnt_idx == 2'(i)) begin
                sel_addr = breq_addr_array_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_type = breq_type_array_i[i*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
            end
        end
    end

    // NOP and reserved types are popped but never reach the FIFO.
    assign sel_real = (sel_type == BROAD_TYPE_WIDTH'(BROAD_TYPE_WR)) ||
                      (sel_type == BROAD_TYPE_WIDTH'(BROAD_TYPE_RD));

    assign grant = (state == IDLE) && (|breq_valid_array_i) &&
                   !fifo_status_full_i && !broad_fifo_wr_o;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            ptr              <= 2'd3;
            id_cnt           <= '0;
            breq_ack_array_o <= '0;
            broad_fifo_wr_o  <= 1'b0;
            broad_addr_o     <= '0;
            broad_type_o     <= '0;
            broad_cpu_id_o   <= '0;
            broad_id_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        breq_ack_array_o <= gnt;
                        ptr              <= gnt_idx;
                        state            <= ISSUE;
                        if (sel_real) begin
                            broad_fifo_wr_o <= 1'b1;
                            broad_addr_o    <= sel_addr;
                            broad_type_o    <= sel_type;
                            broad_cpu_id_o  <= gnt_idx;
                            broad_id_o      <= id_cnt;
                            id_cnt          <= id_cnt + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Dead cycle lets the FIFO's registered full catch up.
                    breq_ack_array_o <= '0;
                    broad_fifo_wr_o  <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MESI_ISC_BREQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_cnt_array_o <= '0;
            stall_cnt_o       <= '0;
        end else begin
            for (int i = 0; i < NUM_CPU; i++) begin
                if (grant && sel_real && (gnt_idx == 2'(i)) &&
                    (grant_cnt_array_o[i*STAT_WIDTH +: STAT_WIDTH] != '1)) begin
                    grant_cnt_array_o[i*STAT_WIDTH +: STAT_WIDTH] <=
                        grant_cnt_array_o[i*STAT_WIDTH +: STAT_WIDTH] + 1'b1;
                end
            end
            if ((state == IDLE) && (|breq_valid_array_i) && fifo_status_full_i &&
                (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// Scoreboard bench for mesi_isc_breq_arb: expected FIFO writes/acks are queued
// at stimulus time and compared when the DUT strobes ack or write.
module tb_mesi_isc_breq_arb;

    logic         clk;
    logic         rst;
    logic [3:0]   valid;
    logic [127:0] addr_arr;
    logic [7:0]   type_arr;
    logic [3:0]   ack;
    logic         full;
    logic         wr;
    logic [31:0]  baddr;
    logic [1:0]   btype;
    logic [1:0]   bcpu;
    logic [4:0]   bid;
`ifdef MESI_ISC_BREQ_STATS_EN
    logic [63:0]  grant_cnt;
    logic [15:0]  stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  ack;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  typ;
        logic [1:0]  cpu;
        logic [4:0]  id;
    } exp_t;

    exp_t sb[$];

    mesi_isc_breq_arb dut (
        .clk                (clk),
        .rst                (rst),
        .breq_valid_array_i (valid),
        .breq_addr_array_i  (addr_arr),
        .breq_type_array_i  (type_arr),
        .breq_ack_array_o   (ack),
        .fifo_status_full_i (full),
        .broad_fifo_wr_o    (wr),
        .broad_addr_o       (baddr),
        .broad_type_o       (btype),
        .broad_cpu_id_o     (bcpu),
`ifdef MESI_ISC_BREQ_STATS_EN
        .grant_cnt_array_o  (grant_cnt),
        .stall_cnt_o        (stall_cnt),
`endif
        .broad_id_o         (bid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic w, input logic [31:0] ad,
                        input logic [1:0] t, input logic [1:0] c, input logic [4:0] i);
        exp_t e;
        e.ack = a; e.wr = w; e.addr = ad; e.typ = t; e.cpu = c; e.id = i;
        sb.push_back(e);
    endtask

    task automatic set_req(input int cpu, input logic [31:0] a, input logic [1:0] t);
        addr_arr[cpu*32 +: 32] = a;
        type_arr[cpu*2 +: 2]   = t;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(1);
        chk("rst_wr", wr, 0);
        chk("rst_ack", ack, 0);
        chk("rst_id", bid, 0);
        rst = 1'b1;
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < n && sb.size() != 0; i++) cyc(1);
        chk("drain", sb.size(), 0);
    endtask

    // Monitor: every ack/write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (full && wr) chk("full_implies_no_wr", wr, 0);
        if (ack != 4'b0 || wr) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {ack, wr}, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_ack", ack, e.ack);
                chk("sb_wr", wr, e.wr);
                if (e.wr) begin
                    chk("sb_addr", baddr, e.addr);
                    chk("sb_type", btype, e.typ);
                    chk("sb_cpu", bcpu, e.cpu);
                    chk("sb_id", bid, e.id);
                end
            end
        end
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: simulation did not complete at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b0;
        valid    = '0;
        full     = 1'b0;
        addr_arr = '0;
        type_arr = '0;
        cyc(2);
        chk("reset_wr", wr, 0);
        chk("reset_ack", ack, 0);
        chk("reset_addr", baddr, 0);
        chk("reset_type", btype, 0);
        chk("reset_cpu", bcpu, 0);
        chk("reset_id", bid, 0);
        rst = 1'b1;
        cyc(1);

        // Single CPU2 write: one-cycle latency, one-cycle strobe.
        set_req(2, 32'h0000_1040, 2'd1);
        valid = 4'b0100;
        push(4'b0100, 1'b1, 32'h0000_1040, 2'd1, 2'd2, 5'd0);
        cyc(1);
        chk("t1_wr", wr, 1);
        chk("t1_ack", ack, 4'b0100);
        valid = '0;
        cyc(1);
        chk("t1_wr_drop", wr, 0);
        chk("t1_ack_drop", ack, 0);
        wait_drain(4);

        // All four valid: round-robin 0,1,2,3,0 every other cycle.
        do_reset();
        for (int c = 0; c < 4; c++) set_req(c, 32'h2000 + 32'(c * 16), 2'd2);
        for (int k = 0; k < 5; k++)
            push(4'b0001 << (k % 4), 1'b1, 32'h2000 + 32'((k % 4) * 16), 2'd2, 2'(k % 4), 5'(k));
        valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("t2_wr_on", wr, 1);
            cyc(1);
            chk("t2_wr_gap", wr, 0);
        end
        valid = '0;
        wait_drain(4);

        // FIFO full holds off CPU1 for 10 cycles, then write one cycle after release.
        full = 1'b1;
        set_req(1, 32'h0000_3000, 2'd1);
        valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk("t3_wr_full", wr, 0);
            chk("t3_ack_full", ack, 0);
        end
        push(4'b0010, 1'b1, 32'h0000_3000, 2'd1, 2'd1, 5'd5);
        full = 1'b0;
        cyc(1);
        chk("t3_wr_release", wr, 1);
        valid = '0;
        cyc(1);
        wait_drain(4);

        // CPU3 NOP is acked without a write; following write keeps id 6.
        set_req(3, 32'h0000_4000, 2'd0);
        valid = 4'b1000;
        push(4'b1000, 1'b0, 32'h0, 2'd0, 2'd0, 5'd0);
        cyc(1);
        chk("t4_nop_ack", ack, 4'b1000);
        chk("t4_nop_wr", wr, 0);
        valid = '0;
        cyc(1);
        set_req(0, 32'h0000_5000, 2'd2);
        valid = 4'b0001;
        push(4'b0001, 1'b1, 32'h0000_5000, 2'd2, 2'd0, 5'd6);
        cyc(1);
        chk("t4_wr_after_nop", wr, 1);
        valid = '0;
        cyc(1);
        wait_drain(4);

        // 33 writes from CPU0: id wraps 31 -> 0.
        do_reset();
        set_req(0, 32'h0000_6000, 2'd1);
        for (int k = 0; k < 33; k++)
            push(4'b0001, 1'b1, 32'h0000_6000, 2'd1, 2'd0, 5'(k % 32));
        valid = 4'b0001;
        cyc(65);
        chk("t5_last_id", bid, 0);
        valid = '0;
        cyc(1);
        wait_drain(4);

        // Reset at the would-be grant edge: nothing issued, then CPU0 wins over CPU1.
        set_req(0, 32'h0000_7000, 2'd1);
        set_req(1, 32'h0000_7100, 2'd1);
        valid = 4'b0011;
        rst   = 1'b0;
        cyc(1);
        chk("t6_rst_wr", wr, 0);
        chk("t6_rst_ack", ack, 0);
        rst = 1'b1;
        push(4'b0001, 1'b1, 32'h0000_7000, 2'd1, 2'd0, 5'd0);
        cyc(1);
        chk("t6_wr", wr, 1);
        chk("t6_cpu", bcpu, 0);
        valid = '0;
        cyc(1);
        wait_drain(4);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mesi_isc_breq_arb.md
Name: mesi_isc_breq_arb

Overview:
- Upstream feeder of mesi_isc_broad.
- Takes pending broadcast requests from the four CPU-side request queues and picks one per grant using round-robin.
- Tags the winner with a rolling broadcast id and writes it into the broadcast FIFO through the broad_fifo_wr/addr/type/cpu_id/id interface.
- Never writes while the FIFO reports full.

Parameters:
ADDR_WIDTH, 32, address width
BROAD_TYPE_WIDTH, 2, broadcast type width
BROAD_ID_WIDTH, 5, broadcast id / tag width
NUM_CPU, 4, requesters (fixed at 4; other values unsupported)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
breq_valid_array_i  input  4  per-CPU request pending
breq_addr_array_i  input  4*ADDR_WIDTH  per-CPU address; CPU n at bits [n*ADDR_WIDTH +: ADDR_WIDTH]
breq_type_array_i  input  4*BROAD_TYPE_WIDTH  per-CPU type
breq_ack_array_o  output  4  one-hot pop pulse to the granted CPU queue
fifo_status_full_i  input  1  broadcast FIFO full (registered inside FIFO)
broad_fifo_wr_o  output  1  FIFO write strobe
broad_addr_o  output  ADDR_WIDTH  address of written entry
broad_type_o  output  BROAD_TYPE_WIDTH  type of written entry
broad_cpu_id_o  output  2  originating CPU
broad_id_o  output  BROAD_ID_WIDTH  broadcast tag

Behaviour:
- Reset (rst==0 at a clk edge):
  - All outputs go to 0.
  - RR pointer goes to 3, so CPU0 has first priority.
  - Id counter goes to 0.
  - An in-flight grant is discarded: no write, no ack.
- Type encoding: 0 NOP, 1 WR_BROAD, 2 RD_BROAD, 3 reserved.
- FSM has two states: IDLE and ISSUE.
- IDLE:
  - Grant condition: any valid, fifo_status_full_i==0, and broad_fifo_wr_o==0.
  - Winner: first valid CPU searching from ptr+1 mod 4 upward.
  - On a grant, the next edge registers addr/type/cpu_id/id, asserts broad_fifo_wr_o and breq_ack_array_o[winner] together for exactly one cycle, sets ptr to the winner, and moves to ISSUE.
- ISSUE:
  - Lasts exactly one cycle; wr and ack deassert, then return to IDLE.
  - Consequence: at most one write every 2 cycles, which gives the FIFO a cycle to update full. Hence fifo_status_full_i |-> !broad_fifo_wr_o must always hold.
- Latency: valid seen at edge t with FIFO not full gives wr/ack high during cycle t+1. The next grant is evaluated at edge t+2.
- Type NOP or 3:
  - Granted normally and acked, so the request is popped.
  - broad_fifo_wr_o stays 0 and the id counter does not advance.
- Id counter: increments by 1 per actual FIFO write and wraps 2^BROAD_ID_WIDTH-1 -> 0. broad_id_o is the pre-increment value.
- Full asserted while requests pend: no grant, no ack, pointer frozen. Granting resumes the first IDLE cycle in which full is 0.
- Requester deasserting valid before grant: legal; request ignored.
- Request payload must be stable while valid is high; the payload is sampled at the grant edge.
- Outputs hold their last values when not writing. Consumers qualify them with broad_fifo_wr_o.

Optional Feature:
- Macro: MESI_ISC_BREQ_STATS_EN.
- When defined:
  - Adds output grant_cnt_array_o (4*16 bits): per-CPU count of actual FIFO writes.
  - Saturates at 16'hFFFF; cleared by reset.
  - Adds output stall_cnt_o (16 bits): counts IDLE cycles with any valid while full is 1; saturating.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package mesi_isc_breq_pkg holds:
  - the type encodings (BROAD_TYPE_NOP/WR/RD)
  - the FSM state enum (IDLE, ISSUE)
  - width defaults shared with mesi_isc_broad
- Sub-module mesi_isc_rr_arb4: combinational 4-way round-robin picker.
  - Inputs: req[3:0] and ptr[1:0].
  - Outputs: gnt one-hot and gnt_idx.
  - The pointer register stays in the parent.

Test Plan:
- Reset then CPU2 valid, addr 32'h0000_1040, type 1 -> one cycle later wr=1, addr 32'h0000_1040, type 1, cpu_id 2, id 0, ack=4'b0100; next cycle wr=0.
- All four valid continuously, FIFO never full -> cpu_id order 0,1,2,3,0 on successive writes spaced 2 cycles; ids 0,1,2,3,4.
- full=1 for 10 cycles with CPU1 valid -> no wr/ack during those cycles; full drops at cycle k -> wr at k+1; assertion full |-> !wr never fires.
- 33 writes from CPU0 -> broad_id sequence wraps 31 -> 0 on the 33rd write.
- CPU3 type 0 -> ack=4'b1000, wr stays 0, next real write still carries the unchanged id.
- rst low at the edge where wr would assert -> wr=0, ack=0, and after release CPU0 wins if valid.
